// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and sizing helpers for the configuration-chain loader.
// Latency: none (types and constant functions only).
// Backpressure: n/a.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    LOADED = 2'd2
  } state_t;

  // Words needed to cover the whole chain (last one may be partial).
  function automatic int num_words(input int chain_len, input int data_w);
    return (chain_len + data_w - 1) / data_w;
  endfunction

  // bits_left must hold CHAIN_LEN itself, hence the +1.
  function automatic int bits_left_w(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction

  function automatic int words_left_w(input int chain_len, input int data_w);
    return $clog2(num_words(chain_len, data_w) + 1);
  endfunction

  // Bits taken from the final word; a zero remainder means a full word.
  function automatic int last_word_bits(input int chain_len, input int data_w);
    int rem;
    rem = chain_len % data_w;
    return (rem == 0) ? data_w : rem;
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Configuration word stream between a bitstream source and the loader.
// Latency: none (wires only).
// Backpressure: word moves on a cycle with in_valid && in_ready.
interface ccff_chain_loader_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/ccff_word_serializer.sv
// Holds one configuration word and emits it LSB-first, one bit per cycle.
// Latency: a word loaded at edge t presents bit 0 during cycle t+1.
// Backpressure: caller may load only when empty or on the held word's last bit.
module ccff_word_serializer
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int DATA_W    = 8
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              load,
  input  logic              load_last,
  input  logic [DATA_W-1:0] load_data,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              last_bit
);

  localparam int             CW       = $clog2(DATA_W + 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DATA_W);
  localparam logic [CW-1:0]  LAST_CNT = CW'(last_word_bits(CHAIN_LEN, DATA_W));

  logic [DATA_W-1:0] sreg;
  logic [CW-1:0]     cnt;
  logic              occ;

  // Load a new word (truncated count on the last one) or shift the held word out.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      sreg <= '0;
      cnt  <= '0;
      occ  <= 1'b0;
    end else if (load) begin
      sreg <= load_data;
      cnt  <= load_last ? LAST_CNT : FULL_CNT;
      occ  <= 1'b1;
    end else if (occ) begin
      sreg <= sreg >> 1;
      cnt  <= cnt - CW'(1);
      if (cnt == CW'(1)) occ <= 1'b0;
    end
  end

  assign bit_out   = sreg[0];
  assign bit_valid = occ;
  assign last_bit  = occ && (cnt == CW'(1));

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads CHAIN_LEN bits LSB-first into a scan/configure DFF chain, then raises cfge.
// Latency: accept at edge t -> bit on chain_si during t+1; cfge CHAIN_LEN+1 cycles after first accept.
// Backpressure: in_ready only in SHIFT with words outstanding and the word register draining.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int DATA_W    = 8
) (
  input  logic                 CK,
  input  logic                 RST,
  input  logic                 start,
  ccff_chain_loader_if.slave   bus,
  output logic                 chain_si,
  output logic                 chain_se,
  output logic                 cfge,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int               BLW        = bits_left_w(CHAIN_LEN);
  localparam int               WLW        = words_left_w(CHAIN_LEN, DATA_W);
  localparam logic [BLW-1:0]   BITS_INIT  = BLW'(CHAIN_LEN);
  localparam logic [WLW-1:0]   WORDS_INIT = WLW'(num_words(CHAIN_LEN, DATA_W));

  state_t         state;
  logic [BLW-1:0] bits_left;
  logic [WLW-1:0] words_left;
  logic           done_q;
  logic           error_q;

  logic ser_bit;
  logic ser_vld;
  logic ser_last;
  logic in_ready_int;
  logic accept;

  // Ready depends only on registered state, so no input reaches an output combinationally.
  assign in_ready_int = (state == SHIFT) && (words_left != '0) && (!ser_vld || ser_last);
  assign accept       = bus.in_valid && in_ready_int;
  assign bus.in_ready = in_ready_int;

  ccff_word_serializer #(
    .CHAIN_LEN (CHAIN_LEN),
    .DATA_W    (DATA_W)
  ) u_ser (
    .CK        (CK),
    .RST       (RST),
    .load      (accept),
    .load_last (words_left == WLW'(1)),
    .load_data (bus.in_data),
    .bit_out   (ser_bit),
    .bit_valid (ser_vld),
    .last_bit  (ser_last)
  );

  // Load FSM: counts words accepted and bits shifted, flags start while busy.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      bits_left  <= '0;
      words_left <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept)  words_left <= words_left - WLW'(1);
      if (ser_vld) bits_left  <= bits_left - BLW'(1);
      case (state)
        IDLE, LOADED: begin
          if (start) begin
            state      <= SHIFT;
            bits_left  <= BITS_INIT;
            words_left <= WORDS_INIT;
            error_q    <= 1'b0;
          end
        end
        SHIFT: begin
          // A start on the final shift cycle still counts as busy.
          if (start) error_q <= 1'b1;
          if (ser_vld && (bits_left == BLW'(1))) begin
            state  <= LOADED;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Chain holds whenever the word register is empty.
  assign chain_se = ser_vld;
  assign chain_si = ser_vld & ser_bit;
  assign busy     = (state == SHIFT);
  assign cfge     = (state == LOADED);
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Bitstream loader placed directly upstream of the configuration flip-flop chain (scan-enabled, configure-enabled DFF cells). It accepts configuration words over a valid/ready stream, serialises them LSB-first onto the chain's scan input with scan-enable, counts exactly `CHAIN_LEN` bits, then asserts the configure-enable that releases the loaded values to the fabric. Reconfiguration is supported by re-issuing `start`.

## Interface
- `CHAIN_LEN`, 64: number of configuration cells in the chain, ≥1.
- `DATA_W`, 8: width of one input word, ≥1.
- `CK`  in  1  clock; also clocks the chain cells.
- `RST`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin a load; ignored while `busy`.
- `in_data`  in  DATA_W  configuration word, bit 0 shifted first.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  word accepted on a cycle with `in_valid && in_ready`.
- `chain_si`  out  1  to SI of chain head.
- `chain_se`  out  1  to SE of all chain cells.
- `cfge`  out  1  to CFGE of all chain cells.
- `busy`  out  1  load in progress.
- `done`  out  1  one-cycle pulse when the last bit has been shifted.
- `error`  out  1  sticky: `start` seen while `busy`.

## Operation
- States: IDLE, SHIFT, LOADED.
- IDLE: `cfge`=0. `start` → SHIFT; loads `bits_left`=CHAIN_LEN and clears `error`.
- SHIFT: `busy`=1, `cfge`=0.
  - A word is held in an internal shift register with an occupancy flag and a bit counter.
  - `in_ready` = occupancy empty, or last bit of the held word is being shifted, gated by `words_left`>0.
  - `words_left` starts at ceil(CHAIN_LEN/DATA_W).
  - Each cycle the register is occupied: `chain_se`=1, `chain_si`=register bit 0; register shifts right; `bits_left` decrements.
  - Empty register: `chain_se`=0, `chain_si`=0. The chain holds its contents; a stall is legal at any bit boundary.
  - Last word: only the low (CHAIN_LEN mod DATA_W) bits are shifted (all DATA_W if remainder is 0). Upper bits are discarded.
  - `bits_left` reaches 0 → LOADED, `done` pulses.
- LOADED: `cfge`=1, `busy`=0, `chain_se`=0.
  - `start` → `cfge` drops in the same cycle as entry to SHIFT. This reloads.
- Bit placement: word 0 bit 0 ends in the tail cell (index CHAIN_LEN-1). The final shifted bit ends in the head cell (index 0).
- `start` while `busy` sets `error` and is otherwise ignored.
- `start` coinciding with the final shift bit counts as busy.
- `in_valid` outside SHIFT: not accepted (`in_ready`=0).
- Reset, including mid-load: all state to IDLE and counters to 0. Chain contents are then undefined.

## Timing
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.
- Reset value of every output is 0.
- `start` at edge N → `busy`=1 and `in_ready`=1 from cycle N+1.
- Word accepted at edge t → its bit 0 is on `chain_si` with `chain_se`=1 during cycle t+1. The chain cell captures it at edge t+2.
- Back-to-back words give continuous `chain_se`=1 with no bubble.
- A minimum full load takes CHAIN_LEN+1 cycles from the first accept to `cfge`=1.
- `done` and `cfge` rise together, on the cycle after the last `chain_se`=1 cycle.

## Structure
- Package `ccff_loader_pkg`:
  - state enum (IDLE/SHIFT/LOADED);
  - `clog2`-based width functions for `bits_left` (clog2(CHAIN_LEN+1)) and `words_left`.
- Sub-module `ccff_word_serializer`: word register, occupancy flag, per-word bit counter, last-word bit-count truncation. It exposes `load`, `bit_out`, `bit_valid`, `last_bit`.
- The top level holds the FSM, `bits_left`/`words_left` counters, `error`, `done`, and `cfge` logic.

## Test plan
- CHAIN_LEN=20, DATA_W=8, words 0xA5, 0x3C, 0xF9 back-to-back:
  - expected 20 consecutive `chain_se`=1 cycles;
  - `chain_si` sequence 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,0,0,1;
  - `cfge`=1 and `done` pulse on the next cycle;
  - a 20-cell chain model reads head→tail as the reverse of that sequence.
- Same load with `in_valid` dropped for 3 cycles after the second word:
  - `chain_se`=0 for exactly 3 cycles;
  - final chain contents identical to the back-to-back case.
- `start` asserted at bit 10 of the load above:
  - `error`=1 and the load completes unaffected;
  - next `start` from LOADED clears `error`, drops `cfge`, and reloads.
- `RST` pulsed at bit 7:
  - all outputs 0 within the reset cycle;
  - `in_ready`=0 until a new `start`;
  - a fresh full load then completes correctly.
- CHAIN_LEN=16, DATA_W=8: exactly 2 words accepted and `in_ready`=0 afterwards. A third `in_valid` word is never consumed.
- CHAIN_LEN=1, DATA_W=8, word 0xFE: one `chain_se` cycle with `chain_si`=0, then `cfge`=1.
